// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Each digit slot lasts SCAN_DIV cycles. The first BLANK_CYC cycles of a slot
// are dark to suppress ghosting. New display data is staged through a
// load/busy handshake and copied into the shadow registers only at the frame
// wrap, so a frame is never drawn from a mix of old and new data.
//
// Handshake: a load pulse captures data_in/dp_in/blank_in into staging and
// raises busy. busy stays high until the next frame wrap copies staging into
// shadow. A load while busy overwrites staging (last write wins). A load that
// coincides with the wrap edge lands in staging after the old staged value has
// moved to shadow, and busy stays high for the following frame.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic        busy,
  output logic        frame_start,
  output logic [3:0]  AN,
  output logic [6:0]  seg,
  output logic        seg_P
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan position.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          slot_end, wrap;

  // Handshake state: staging holds the requested value, shadow the displayed one.
  logic          pend_q, pend_d;
  logic [15:0]   stg_data_q, stg_data_d;
  logic [3:0]    stg_dp_q, stg_dp_d;
  logic [3:0]    stg_blank_q, stg_blank_d;
  logic [15:0]   shd_data_q, shd_data_d;
  logic [3:0]    shd_dp_q, shd_dp_d;
  logic [3:0]    shd_blank_q, shd_blank_d;

  // Registered pin drivers.
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          segp_q, segp_d;
  logic          fs_q, fs_d;

  // Slot counter and digit index; the wrap is the last cycle of digit 3.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
  end

  // Load staging and frame-aligned shadow update.
  always_comb begin
    pend_d      = pend_q;
    stg_data_d  = stg_data_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    if (wrap && pend_q) begin
      shd_data_d  = stg_data_q;
      shd_dp_d    = stg_dp_q;
      shd_blank_d = stg_blank_q;
      pend_d      = 1'b0;
    end
    // A load on the wrap edge still wins pending for the next frame.
    if (load) begin
      stg_data_d  = data_in;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
      pend_d      = 1'b1;
    end
  end

  // Next pin values from the pre-edge scan position and shadow contents.
  always_comb begin
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    segp_d = 1'b1;
    fs_d   = wrap;
    if (!(cnt_q < BLANK_END) && !shd_blank_q[idx_q]) begin
      an_d   = ~(4'b0001 << idx_q);
      seg_d  = hex_to_seg(shd_data_q[{idx_q, 2'b00} +: 4]);
      segp_d = ~shd_dp_q[idx_q];
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pend_q      <= 1'b0;
      stg_data_q  <= 16'h0000;
      stg_dp_q    <= 4'h0;
      stg_blank_q <= 4'h0;
      shd_data_q  <= 16'h0000;
      shd_dp_q    <= 4'h0;
      shd_blank_q <= 4'h0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      segp_q      <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      stg_data_q  <= stg_data_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      shd_data_q  <= shd_data_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      segp_q      <= segp_d;
      fs_q        <= fs_d;
    end
  end

  assign busy        = pend_q;
  assign frame_start = fs_q;
  assign AN          = an_q;
  assign seg         = seg_q;
  assign seg_P       = segp_q;

endmodule
